// File: rtl/sramc_pkg.sv
// Shared widths, arbiter state encoding and the SRAM command bundle for sramc_arb.
// Zero latency (types only). No flow control of its own.
package sramc_pkg;
  localparam int SRAM_AW       = 14;
  localparam int SRAM_DW       = 32;
  localparam int SRAM_BW       = SRAM_DW / 8;
  localparam int SRAM_MAX_LOCK = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic               we;
    logic [SRAM_AW-1:0] addr;
    logic [SRAM_BW-1:0] be;
    logic [SRAM_DW-1:0] wdata;
  } sram_cmd_t;

  function automatic arb_state_e own_state(input logic port);
    return port ? OWN1 : OWN0;
  endfunction
endpackage

// File: rtl/sramc_arb_if.sv
// Requester-side bundle of the two-port SRAM arbiter: commands in, grants and read return out.
// Grant is same-cycle; read data returns one cycle after the grant.
interface sramc_arb_if #(
  parameter int AW = sramc_pkg::SRAM_AW,
  parameter int DW = sramc_pkg::SRAM_DW
);
  logic [1:0]             req_i;
  logic [1:0]             lock_i;
  logic [1:0]             we_i;
  logic [1:0][AW-1:0]     addr_i;
  logic [1:0][DW/8-1:0]   be_i;
  logic [1:0][DW-1:0]     wdata_i;
  logic [1:0]             gnt_o;
  logic [1:0]             rvalid_o;
  logic [DW-1:0]          rdata_o;

  modport master (
    output req_i, lock_i, we_i, addr_i, be_i, wdata_i,
    input  gnt_o, rvalid_o, rdata_o
  );

  modport slave (
    input  req_i, lock_i, we_i, addr_i, be_i, wdata_i,
    output gnt_o, rvalid_o, rdata_o
  );
endinterface

// File: rtl/sramc_arb_rr.sv
// Stateless 2-way round-robin picker: on contention the port not served last wins.
// Purely combinational; a port that does not request never gets a grant.
module sramc_arb_rr (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end
endmodule

// File: rtl/sramc_arb.sv
// Shares one SRAM between two requesters: round-robin, bounded locking, 0-cycle command, 1-cycle read return.
// Losers simply see gnt_o low and retry; optional per-port counters under SRAMC_ARB_STATS_EN.
module sramc_arb
  import sramc_pkg::*;
#(
  parameter int AW       = SRAM_AW,
  parameter int DW       = SRAM_DW,
  parameter int MAX_LOCK = SRAM_MAX_LOCK
) (
  input  logic              hclk,
  input  logic              hresetn,
  sramc_arb_if.slave        bus,
  output logic              sram_cs_o,
  output logic              sram_we_o,
  output logic [AW-1:0]     sram_addr_o,
  output logic [DW/8-1:0]   sram_be_o,
  output logic [DW-1:0]     sram_wdata_o,
  input  logic [DW-1:0]     sram_rdata_i
`ifdef SRAMC_ARB_STATS_EN
  ,
  output logic [1:0][31:0]  gnt_cnt_o,
  output logic [1:0][31:0]  stall_cnt_o
`endif
);
  localparam int CW = $clog2(MAX_LOCK + 1);

  arb_state_e    state, state_nxt;
  logic          last, last_nxt;
  logic [CW-1:0] lock_cnt, lock_cnt_nxt;
  logic [1:0]    rr_gnt, gnt_raw, gnt;
  logic          owner, owned, lock_hit, free_arb, sel;
  logic          rd_vld, rd_id;
  sram_cmd_t     cmd;

  sramc_arb_rr u_rr (
    .req  (bus.req_i),
    .last (last),
    .gnt  (rr_gnt)
  );

  assign owner    = (state == OWN1);
  assign owned    = (state != IDLE);
  assign lock_hit = owned && (lock_cnt == CW'(MAX_LOCK));
  // Plain round-robin applies when nobody owns the array, the owner went quiet,
  // or the owner has used up its lock budget against a waiting peer.
  assign free_arb = !owned || !bus.req_i[owner] || lock_hit;

  always_comb begin
    gnt_raw      = 2'b00;
    state_nxt    = IDLE;
    last_nxt     = last;
    lock_cnt_nxt = lock_cnt;
    if (free_arb) begin
      gnt_raw = rr_gnt;
    end else begin
      gnt_raw = owner ? 2'b10 : 2'b01;
    end
    if (|gnt_raw) begin
      last_nxt  = gnt_raw[1];
      state_nxt = bus.lock_i[gnt_raw[1]] ? own_state(gnt_raw[1]) : IDLE;
    end
    if ((state_nxt != state) || !bus.req_i[~owner]) begin
      lock_cnt_nxt = '0;
    end else if (owned && gnt_raw[owner]) begin
      lock_cnt_nxt = lock_cnt + CW'(1);
    end
  end

  // Grants are held low while reset is asserted so nothing reaches the SRAM.
  assign gnt = gnt_raw & {2{hresetn}};
  assign sel = gnt[1];

  always_comb begin
    cmd = '0;
    if (|gnt) begin
      cmd.we    = bus.we_i[sel];
      cmd.addr  = bus.addr_i[sel];
      cmd.be    = bus.be_i[sel];
      cmd.wdata = bus.wdata_i[sel];
    end
  end

  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      state    <= IDLE;
      last     <= 1'b1;
      lock_cnt <= '0;
      rd_vld   <= 1'b0;
      rd_id    <= 1'b0;
    end else begin
      state    <= state_nxt;
      last     <= last_nxt;
      lock_cnt <= lock_cnt_nxt;
      rd_vld   <= (|gnt) && !cmd.we;
      rd_id    <= sel;
    end
  end

  assign sram_cs_o    = |gnt;
  assign sram_we_o    = cmd.we;
  assign sram_addr_o  = cmd.addr;
  assign sram_be_o    = cmd.be;
  assign sram_wdata_o = cmd.wdata;

  assign bus.gnt_o    = gnt;
  assign bus.rvalid_o = {2{rd_vld && hresetn}} & {rd_id, ~rd_id};
  assign bus.rdata_o  = (rd_vld && hresetn) ? sram_rdata_i : '0;

`ifdef SRAMC_ARB_STATS_EN
  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      gnt_cnt_o   <= '0;
      stall_cnt_o <= '0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (bus.req_i[p] && gnt[p] && (gnt_cnt_o[p] != '1)) begin
          gnt_cnt_o[p] <= gnt_cnt_o[p] + 32'd1;
        end
        if (bus.req_i[p] && !gnt[p] && (stall_cnt_o[p] != '1)) begin
          stall_cnt_o[p] <= stall_cnt_o[p] + 32'd1;
        end
      end
    end
  end
`endif
endmodule

// File: tb/tb_sramc_arb.sv
// Directed bench for sramc_arb with a byte-writable SRAM model behind it.
// Inputs change 1ns after the rising edge; outputs are compared 1ns later.
module tb_sramc_arb;
  logic        hclk;
  logic        hresetn;
  logic        sram_cs, sram_we;
  logic [13:0] sram_addr;
  logic [3:0]  sram_be;
  logic [31:0] sram_wdata, sram_rdata;
  logic [31:0] mem [0:16383];
  logic        mem_init = 1'b0;
  int          nvec = 0;
  int          nerr = 0;
`ifdef SRAMC_ARB_STATS_EN
  logic [1:0][31:0] gnt_cnt, stall_cnt;
`endif

  sramc_arb_if bus ();

  sramc_arb dut (
    .hclk         (hclk),
    .hresetn      (hresetn),
    .bus          (bus),
    .sram_cs_o    (sram_cs),
    .sram_we_o    (sram_we),
    .sram_addr_o  (sram_addr),
    .sram_be_o    (sram_be),
    .sram_wdata_o (sram_wdata),
    .sram_rdata_i (sram_rdata)
`ifdef SRAMC_ARB_STATS_EN
    ,
    .gnt_cnt_o    (gnt_cnt),
    .stall_cnt_o  (stall_cnt)
`endif
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  // SRAM model: first edge loads the known contents, then read data appears one cycle after cs.
  always @(posedge hclk) begin
    if (!mem_init) begin
      mem[14'h0010] <= 32'hDEADBEEF;
      mem[14'h0001] <= 32'hA5A50001;
      mem[14'h0002] <= 32'h5A5A0002;
      mem[14'h3FFF] <= 32'hAABBCCDD;
      mem_init      <= 1'b1;
    end else if (sram_cs) begin
      if (sram_we) begin
        for (int b = 0; b < 4; b++) begin
          if (sram_be[b]) mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
        end
      end else begin
        sram_rdata <= mem[sram_addr];
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge hclk);
    #1;
  endtask

  task automatic set_idle();
    bus.req_i   = 2'b00;
    bus.lock_i  = 2'b00;
    bus.we_i    = 2'b00;
    bus.addr_i  = '0;
    bus.be_i    = '0;
    bus.wdata_i = '0;
  endtask

  task automatic do_reset();
    hresetn = 1'b0;
    set_idle();
    step();
    step();
    hresetn = 1'b1;
  endtask

  task automatic test_reset();
    hresetn     = 1'b0;
    set_idle();
    bus.req_i   = 2'b11;
    bus.addr_i[0] = 14'h0123;
    bus.wdata_i[1] = 32'hCAFEF00D;
    step();
    step();
    #1;
    nvec++; if (bus.gnt_o !== 2'b00) begin nerr++; $display("FAIL rst_gnt: got %b want 00", bus.gnt_o); end
    nvec++; if (bus.rvalid_o !== 2'b00) begin nerr++; $display("FAIL rst_rvalid: got %b want 00", bus.rvalid_o); end
    nvec++; if (bus.rdata_o !== 32'h0) begin nerr++; $display("FAIL rst_rdata: got %h want 0", bus.rdata_o); end
    nvec++; if (sram_cs !== 1'b0 || sram_we !== 1'b0) begin nerr++; $display("FAIL rst_cs_we: got %b%b want 00", sram_cs, sram_we); end
    nvec++; if (sram_addr !== 14'h0 || sram_be !== 4'h0 || sram_wdata !== 32'h0) begin
      nerr++; $display("FAIL rst_bus: got addr %h be %h wdata %h want all 0", sram_addr, sram_be, sram_wdata);
    end
    set_idle();
    hresetn = 1'b1;
    step();
  endtask

  task automatic test_read_basic();
    bus.req_i     = 2'b01;
    bus.we_i      = 2'b00;
    bus.addr_i[0] = 14'h0010;
    #1;
    nvec++; if (bus.gnt_o !== 2'b01) begin nerr++; $display("FAIL rd_gnt: got %b want 01", bus.gnt_o); end
    nvec++; if (sram_cs !== 1'b1 || sram_we !== 1'b0 || sram_addr !== 14'h0010) begin
      nerr++; $display("FAIL rd_cmd: got cs %b we %b addr %h want 1 0 0010", sram_cs, sram_we, sram_addr);
    end
    step();
    set_idle();
    #1;
    nvec++; if (bus.rvalid_o !== 2'b01) begin nerr++; $display("FAIL rd_rvalid: got %b want 01", bus.rvalid_o); end
    nvec++; if (bus.rdata_o !== 32'hDEADBEEF) begin nerr++; $display("FAIL rd_rdata: got %h want deadbeef", bus.rdata_o); end
    nvec++; if (bus.gnt_o !== 2'b00) begin nerr++; $display("FAIL rd_idle_gnt: got %b want 00", bus.gnt_o); end
    step();
  endtask

  task automatic test_alternate();
    logic [1:0] exp;
    do_reset();
    bus.req_i      = 2'b11;
    bus.we_i       = 2'b11;
    bus.addr_i[0]  = 14'h0100;
    bus.addr_i[1]  = 14'h0200;
    bus.be_i[0]    = 4'hF;
    bus.be_i[1]    = 4'hF;
    bus.wdata_i[0] = 32'h00000A00;
    bus.wdata_i[1] = 32'h00000B11;
    for (int i = 0; i < 6; i++) begin
      exp = (i % 2 == 0) ? 2'b01 : 2'b10;
      #1;
      nvec++; if (bus.gnt_o !== exp) begin nerr++; $display("FAIL alt_gnt[%0d]: got %b want %b", i, bus.gnt_o, exp); end
      nvec++; if (sram_wdata !== (exp[0] ? 32'h00000A00 : 32'h00000B11)) begin
        nerr++; $display("FAIL alt_wdata[%0d]: got %h want %h", i, sram_wdata, exp[0] ? 32'h00000A00 : 32'h00000B11);
      end
      nvec++; if (bus.rvalid_o !== 2'b00) begin nerr++; $display("FAIL alt_rvalid[%0d]: got %b want 00", i, bus.rvalid_o); end
      step();
    end
    set_idle();
    step();
  endtask

  task automatic test_lock();
    logic [1:0] exp;
    bus.req_i      = 2'b10;
    bus.lock_i     = 2'b10;
    bus.we_i       = 2'b10;
    bus.be_i[1]    = 4'hF;
    bus.addr_i[1]  = 14'h0300;
    #1;
    nvec++; if (bus.gnt_o !== 2'b10) begin nerr++; $display("FAIL lock_enter: got %b want 10", bus.gnt_o); end
    step();
    bus.req_i     = 2'b11;
    bus.we_i      = 2'b11;
    bus.be_i[0]   = 4'hF;
    bus.addr_i[0] = 14'h0301;
    for (int i = 0; i < 10; i++) begin
      exp = (i == 8) ? 2'b01 : 2'b10;
      #1;
      nvec++; if (bus.gnt_o !== exp) begin nerr++; $display("FAIL lock_gnt[%0d]: got %b want %b", i, bus.gnt_o, exp); end
      step();
    end
    set_idle();
    step();
  endtask

  task automatic test_rd_alt();
    bus.req_i     = 2'b01;
    bus.we_i      = 2'b00;
    bus.addr_i[0] = 14'h0001;
    bus.addr_i[1] = 14'h0002;
    #1;
    nvec++; if (bus.gnt_o !== 2'b01) begin nerr++; $display("FAIL ra_gnt0: got %b want 01", bus.gnt_o); end
    nvec++; if (bus.rvalid_o !== 2'b00) begin nerr++; $display("FAIL ra_rv0: got %b want 00", bus.rvalid_o); end
    step();
    bus.req_i = 2'b10;
    #1;
    nvec++; if (bus.gnt_o !== 2'b10) begin nerr++; $display("FAIL ra_gnt1: got %b want 10", bus.gnt_o); end
    nvec++; if (bus.rvalid_o !== 2'b01) begin nerr++; $display("FAIL ra_rv1: got %b want 01", bus.rvalid_o); end
    nvec++; if (bus.rdata_o !== 32'hA5A50001) begin nerr++; $display("FAIL ra_rd1: got %h want a5a50001", bus.rdata_o); end
    step();
    set_idle();
    #1;
    nvec++; if (bus.rvalid_o !== 2'b10) begin nerr++; $display("FAIL ra_rv2: got %b want 10", bus.rvalid_o); end
    nvec++; if (bus.rdata_o !== 32'h5A5A0002) begin nerr++; $display("FAIL ra_rd2: got %h want 5a5a0002", bus.rdata_o); end
    step();
    #1;
    nvec++; if (bus.rvalid_o !== 2'b00) begin nerr++; $display("FAIL ra_rv3: got %b want 00", bus.rvalid_o); end
  endtask

  task automatic test_byte_write();
    bus.req_i      = 2'b01;
    bus.we_i       = 2'b01;
    bus.addr_i[0]  = 14'h3FFF;
    bus.be_i[0]    = 4'b0011;
    bus.wdata_i[0] = 32'h12345678;
    #1;
    nvec++; if (bus.gnt_o !== 2'b01) begin nerr++; $display("FAIL bw_gnt: got %b want 01", bus.gnt_o); end
    nvec++; if (sram_be !== 4'b0011 || sram_addr !== 14'h3FFF) begin
      nerr++; $display("FAIL bw_cmd: got be %b addr %h want 0011 3fff", sram_be, sram_addr);
    end
    nvec++; if (sram_we !== 1'b1 || sram_wdata !== 32'h12345678) begin
      nerr++; $display("FAIL bw_data: got we %b wdata %h want 1 12345678", sram_we, sram_wdata);
    end
    step();
    bus.we_i   = 2'b00;
    bus.be_i[0] = 4'b0000;
    #1;
    nvec++; if (bus.rvalid_o !== 2'b00) begin nerr++; $display("FAIL bw_no_rvalid: got %b want 00", bus.rvalid_o); end
    step();
    set_idle();
    #1;
    nvec++; if (bus.rvalid_o !== 2'b01) begin nerr++; $display("FAIL bw_rb_rv: got %b want 01", bus.rvalid_o); end
    nvec++; if (bus.rdata_o !== 32'hAABB5678) begin nerr++; $display("FAIL bw_rb_data: got %h want aabb5678", bus.rdata_o); end
    step();
  endtask

  task automatic test_reset_mid();
    bus.req_i     = 2'b01;
    bus.we_i      = 2'b00;
    bus.addr_i[0] = 14'h0010;
    #1;
    nvec++; if (bus.gnt_o !== 2'b01) begin nerr++; $display("FAIL rm_gnt: got %b want 01", bus.gnt_o); end
    step();
    hresetn        = 1'b0;
    bus.req_i      = 2'b11;
    bus.we_i       = 2'b11;
    bus.be_i[0]    = 4'hF;
    bus.be_i[1]    = 4'hF;
    bus.addr_i[0]  = 14'h0100;
    bus.addr_i[1]  = 14'h0200;
    for (int i = 0; i < 2; i++) begin
      #1;
      nvec++; if (bus.rvalid_o !== 2'b00 || bus.rdata_o !== 32'h0) begin
        nerr++; $display("FAIL rm_rv[%0d]: got rvalid %b rdata %h want 00 0", i, bus.rvalid_o, bus.rdata_o);
      end
      nvec++; if (bus.gnt_o !== 2'b00 || sram_cs !== 1'b0) begin
        nerr++; $display("FAIL rm_gnt_rst[%0d]: got gnt %b cs %b want 00 0", i, bus.gnt_o, sram_cs);
      end
      step();
    end
    hresetn = 1'b1;
    #1;
    nvec++; if (bus.gnt_o !== 2'b01) begin nerr++; $display("FAIL rm_first: got %b want 01", bus.gnt_o); end
    nvec++; if (bus.rvalid_o !== 2'b00) begin nerr++; $display("FAIL rm_stale_rv: got %b want 00", bus.rvalid_o); end
    step();
    #1;
    nvec++; if (bus.gnt_o !== 2'b10) begin nerr++; $display("FAIL rm_second: got %b want 10", bus.gnt_o); end
    set_idle();
    step();
  endtask

  initial begin
    test_reset();
    test_read_basic();
    test_alternate();
    test_lock();
    test_rd_alt();
    test_byte_write();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/sramc_arb.md
# sramc_arb

Two-port arbiter that shares the single sram8x8k array (16K x 32-bit words, byte-writable) between the AHB slave interface (port 0) and a secondary requester such as a BIST or DMA engine (port 1). It sits between the requesters and the SRAM command inputs. It grants at most one access per cycle, using round-robin fairness, owner locking with a bounded hold, and read-data return routing. It replaces the direct AHB-to-SRAM connection inside the SRAM controller top level.

## Interface
- AW, 14, word address width (16K words)
- DW, 32, data width; byte enables are DW/8
- MAX_LOCK, 8, max consecutive locked grants while the other port is requesting
- hclk  in  1  clock
- hresetn  in  1  synchronous active-low reset
- req_i[2]  in  2  per-port access request
- lock_i[2]  in  2  per-port lock: keep grant after this access
- we_i[2]  in  2  per-port write (1) / read (0)
- addr_i[2]  in  2xAW  per-port word address
- be_i[2]  in  2x(DW/8)  per-port byte enables
- wdata_i[2]  in  2xDW  per-port write data
- gnt_o[2]  out  2  per-port grant; req&gnt = access accepted this cycle
- rvalid_o[2]  out  2  per-port read data valid
- rdata_o  out  DW  read data, shared by both ports and qualified by rvalid_o
- sram_cs_o  out  1  SRAM access strobe
- sram_we_o  out  1  SRAM write
- sram_addr_o  out  AW  SRAM address
- sram_be_o  out  DW/8  SRAM byte enables
- sram_wdata_o  out  DW  SRAM write data
- sram_rdata_i  in  DW  SRAM read data, valid one cycle after a read strobe

## Operation
- FSM states are IDLE, OWN0 and OWN1. Reset state is IDLE. The last-served flag resets to 1, so port 0 wins the first contention.
- IDLE: if exactly one port requests, that port is granted. If both request, the port that was not last served is granted. With no request the FSM stays in IDLE.
- A granted access with lock_i=1 moves the FSM to OWN<n>. Otherwise the FSM returns to IDLE, and next-cycle arbitration is done again as in IDLE.
- OWN<n>: port n has absolute priority. The FSM exits to IDLE when req_i[n]=0, or when an access with lock_i[n]=0 is accepted.
- Lock counter: it increments on each granted access in OWN<n> while the other port requests, and clears on any state change or when the other port is idle. When it reaches MAX_LOCK, the FSM is forced to IDLE and the other port wins the next cycle.
- The command mux drives the sram_* outputs from the granted port. When there is no grant, sram_cs_o=0 and the other sram_* outputs are 0.
- Read return uses a registered tag (valid + port id). rvalid_o[id] pulses one cycle after the read grant, and rdata_o = sram_rdata_i.
- Write accesses produce no rvalid. Back-to-back reads from alternating ports each return in order, one per cycle.

## Timing
- gnt_o is combinational from req_i, lock_i, state and the last-served flag. There is no combinational path from sram_rdata_i to gnt_o.
- Access latency is 0 cycles (command presented in the grant cycle). Read data latency is 1 cycle after the grant.
- Throughput is 1 access per cycle, sustained.
- Reset values: gnt_o=0, rvalid_o=0, rdata_o=0, sram_cs_o=0, sram_we_o=0, all sram_* buses 0, lock counter 0.
- Reset mid-operation drops any pending read return (no rvalid_o after reset).
- Simultaneous request from the owner in OWN<n> and the other port: the owner is granted, unless the lock counter has reached MAX_LOCK.

## Configuration
- SRAMC_ARB_STATS_EN defined: adds outputs gnt_cnt_o[2] (32-bit each) and stall_cnt_o[2] (32-bit each).
  - gnt_cnt_o counts accepted accesses per port.
  - stall_cnt_o counts cycles with req_i[n]=1 and gnt_o[n]=0.
  - All counters saturate at all-ones and clear on reset.
- Not defined: these ports and counters are absent, and the behaviour is otherwise identical.

## Structure
- sramc_pkg holds the following:
  - the AW, DW and MAX_LOCK defaults;
  - the arb_state_e enum (IDLE, OWN0, OWN1);
  - a sram_cmd_t struct (we, addr, be, wdata).
- Sub-module sramc_arb_rr is the 2-way round-robin picker. It takes req[2] and last, and returns a one-hot grant. All state lives in sramc_arb.

## Test plan
- Reset, then port 0 reads addr 0x0010 (SRAM holds 0xDEADBEEF) -> gnt_o=01 in the same cycle, then rvalid_o=01 and rdata_o=0xDEADBEEF one cycle later.
- Both ports request continuous single writes without lock -> grants alternate 01, 10, 01 …, with port 0 first after reset.
- Port 1 holds lock_i=1 with continuous requests while port 0 requests, MAX_LOCK=8 -> port 1 gets 8 grants, then port 0 is granted on the 9th cycle.
- Port 0 reads 0x0001 and port 1 reads 0x0002 in consecutive cycles -> rvalid_o=01 then 10, each with the matching data, with no overlap.
- Port 0 write with be=0011 and data 0x12345678 to 0x3FFF -> sram_be_o=0011 and sram_addr_o=0x3FFF. A readback returns 0xxxxx5678 with the upper bytes unchanged.
- hresetn is asserted in the cycle after a read grant -> no rvalid_o, all outputs 0, and the first arbitration after reset goes to port 0.
